i2c_txn_scheduler: RTL and testbench
====================================

// Module: i2c_txn_scheduler
// PURPOSE
//  Shares one byte-level I2C master engine between NUM_REQ register-access clients.
//  Round-robin arbiter plus transaction sequencer. For each granted request it issues
//  the full command list: START, device address, register address, then either data
//  bytes or a repeated-START read of 1-4 bytes, then STOP. Returns read data and
//  status to the granted client. Sits between the system logic and the I2C_main-style
//  byte engine on the gpdi_sda/gpdi_scl bus.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  TIMEOUT_CYC  4096  clk cycles allowed per engine command (I2C_TIMEOUT_EN only)
// PORTS
//  clk          in   1          system clock; all logic on posedge
//  rst          in   1          asynchronous reset, active-high
//  req_valid    in   NUM_REQ    request pending; held until matching req_done
//  req_rw       in   NUM_REQ    0 = register write, 1 = register read
//  req_dev      in   7*NUM_REQ  7-bit device address per client
//  req_reg      in   8*NUM_REQ  register address per client
//  req_len      in   2*NUM_REQ  byte count minus 1 (0..3 -> 1..4 bytes)
//  req_wdata    in   32*NUM_REQ write bytes; byte0 = [7:0] is sent first
//  req_done     out  NUM_REQ    1-cycle pulse to the granted client at completion
//  req_err      out  1          valid with req_done: slave NACK or timeout
//  rdata        out  32         read bytes, byte0 in [7:0]; unread bytes zero
//  busy         out  1          high from grant until the req_done cycle
//  cmd_valid    out  1          engine command valid
//  cmd_ready    in   1          engine accepts command when valid & ready
//  cmd_op       out  3          0 START, 1 RSTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP
//  cmd_byte     out  8          byte for WRITE (addr byte = {dev, rw})
//  rsp_valid    in   1          engine finished current command (1-cycle pulse)
//  rsp_nack     in   1          with rsp_valid after WRITE: slave NACKed
//  rsp_byte     in   8          with rsp_valid after READ_*: received byte
//  timeout      out  1          1-cycle pulse on command timeout (0 without macro)
// BEHAVIOUR
//  Reset: FSM IDLE; rr pointer 0; req_done 0, req_err 0, rdata 0, busy 0,
//   cmd_valid 0, cmd_op 0, cmd_byte 0, timeout 0. Reset mid-transaction abandons it:
//   no STOP issued, no req_done. The engine shares rst.
//  States: IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, RDATA, STOP, DONE.
//   Each state issues one command, then waits for rsp_valid. At most 1 command is
//   outstanding. cmd_valid drops the cycle after the handshake.
//  IDLE: if any req_valid, grant the lowest index >= rr pointer, wrapping around.
//   Latch dev/reg/rw/len/wdata. Go to START next cycle, busy=1. Grant decision takes
//   1 cycle. Requests arriving during busy wait; latched fields are not re-sampled.
//  Sequence: START -> DEVW(byte {dev,0}) -> REG(reg).
//   Write: WDATA issues len+1 WRITE bytes -> STOP.
//   Read: RSTART -> DEVR({dev,1}) -> RDATA issues len READ_ACK, then 1 READ_NACK -> STOP.
//  rdata: byte k stored at rdata[8k+7:8k] on its rsp_valid. Cleared to 0 at grant.
//  NACK: rsp_nack=1 on any WRITE aborts remaining bytes -> STOP -> DONE with err=1.
//  DONE: pulse req_done[grant] and req_err for 1 cycle; busy drops the same cycle.
//   rr pointer <= grant+1 mod NUM_REQ. Return to IDLE; earliest new grant 1 cycle later.
//  Byte counter 2 bits, counts 0..len; no wrap beyond len.
//  rsp_valid while no command is outstanding is ignored.
//  A request deasserted mid-transaction is still completed and still gets req_done.
//  Transaction length in commands: write = 4+len+1, read = 6+len+1.
// CONFIGURATION
//  I2C_TIMEOUT_EN defined: a 16-bit counter runs while waiting on cmd_ready or
//   rsp_valid. It reloads on each handshake. On reaching TIMEOUT_CYC:
//   - pulse timeout, drop cmd_valid, skip STOP (engine assumed hung);
//   - go to DONE with req_err=1.
//  I2C_TIMEOUT_EN undefined: no counter, timeout tied 0, waits are unbounded.
// TESTING
//  Write: req0 rw=0 dev=7'h50 reg=8'h10 len=1 wdata=32'h0000_BEEF, engine ACKs all
//   -> ops START, WRITE A0, WRITE 10, WRITE EF, WRITE BE, STOP; req_done[0], err=0.
//  Read: req1 rw=1 dev=7'h50 reg=8'h20 len=2, engine returns 11,22,33
//   -> ops ..., RSTART, WRITE A1, READ_ACK x2, READ_NACK, STOP; rdata=32'h0033_2211.
//  NACK on device address: rsp_nack=1 after WRITE A0 -> next op STOP; req_done, err=1.
//  Arbitration: req_valid=4'b1111 held for 4 transactions from rr=0 -> grants 0,1,2,3.
//   Then req 2,3 pending with rr=3 -> grant 3 then 2.
//  Reset mid-read after the 2nd READ_ACK -> all outputs at reset values next cycle.
//   No req_done. A fresh request afterwards completes normally.
//  I2C_TIMEOUT_EN, TIMEOUT_CYC=16, cmd_ready stuck 0 -> timeout pulse after 16 cycles.
//   No STOP issued; req_done with err=1.

Source files
------------

// File: rtl/i2c_txn_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : i2c_txn_scheduler
// Brief    : Round-robin arbiter and command sequencer sharing one byte-level
//            I2C master engine between NUM_REQ register-access clients.
//            Optional macro I2C_TIMEOUT_EN adds a per-command watchdog.
// Revision : 1.0
// =============================================================================
module i2c_txn_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_rw,
    input  logic [7*NUM_REQ-1:0]  req_dev,
    input  logic [8*NUM_REQ-1:0]  req_reg,
    input  logic [2*NUM_REQ-1:0]  req_len,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  req_err,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [2:0]            cmd_op,
    output logic [7:0]            cmd_byte,
    input  logic                  rsp_valid,
    input  logic                  rsp_nack,
    input  logic [7:0]            rsp_byte,
    output logic                  timeout
);

    localparam int c_GW = $clog2(NUM_REQ);

    localparam logic [2:0] c_OP_START  = 3'd0;
    localparam logic [2:0] c_OP_RSTART = 3'd1;
    localparam logic [2:0] c_OP_WRITE  = 3'd2;
    localparam logic [2:0] c_OP_RACK   = 3'd3;
    localparam logic [2:0] c_OP_RNACK  = 3'd4;
    localparam logic [2:0] c_OP_STOP   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_DEVW   = 4'd2,
        S_REG    = 4'd3,
        S_WDATA  = 4'd4,
        S_RSTART = 4'd5,
        S_DEVR   = 4'd6,
        S_RDATA  = 4'd7,
        S_STOP   = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t          r_state;
    logic [c_GW-1:0] r_rr;
    logic [c_GW-1:0] r_gnt;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic            r_rw;
    logic [1:0]      r_len;
    logic [31:0]     r_wdata;
    logic [1:0]      r_cnt;
    logic            r_err;
    logic            r_outst;

    logic [c_GW-1:0] w_gnt;
    logic            w_any;
    logic [1:0]      w_cnt_inc;
    logic [7:0]      w_wbyte;
    logic            w_is_wr;
    logic            w_tmo_hit;

    // Search starts at the round-robin pointer; the lowest offset wins.
    always_comb begin
        int k;
        w_any = 1'b0;
        w_gnt = '0;
        k     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = int'(r_rr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (req_valid[k]) begin
                w_any = 1'b1;
                w_gnt = c_GW'(k);
            end
        end
    end

    assign w_cnt_inc = r_cnt + 2'd1;
    assign w_wbyte   = r_wdata[{w_cnt_inc, 3'b000} +: 8];
    assign w_is_wr   = r_state inside {S_DEVW, S_REG, S_WDATA, S_DEVR};

`ifdef I2C_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        w_waiting;
    logic        w_progress;

    assign w_waiting  = cmd_valid | r_outst;
    assign w_progress = (cmd_valid & cmd_ready) | (r_outst & rsp_valid);
    assign w_tmo_hit  = w_waiting & ~w_progress & (r_tmo_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (!w_waiting || w_progress || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr      <= '0;
            r_gnt     <= '0;
            r_dev     <= '0;
            r_reg     <= '0;
            r_rw      <= 1'b0;
            r_len     <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_outst   <= 1'b0;
            req_done  <= '0;
            req_err   <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= c_OP_START;
            cmd_byte  <= '0;
            timeout   <= 1'b0;
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            timeout  <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
                r_outst   <= 1'b1;
            end
            if (w_tmo_hit) begin
                // Engine presumed hung, so no STOP is attempted.
                timeout         <= 1'b1;
                cmd_valid       <= 1'b0;
                r_outst         <= 1'b0;
                req_done[r_gnt] <= 1'b1;
                req_err         <= 1'b1;
                busy            <= 1'b0;
                r_state         <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_any) begin
                            r_gnt     <= w_gnt;
                            r_rw      <= req_rw[w_gnt];
                            r_dev     <= req_dev[7*int'(w_gnt) +: 7];
                            r_reg     <= req_reg[8*int'(w_gnt) +: 8];
                            r_len     <= req_len[2*int'(w_gnt) +: 2];
                            r_wdata   <= req_wdata[32*int'(w_gnt) +: 32];
                            r_err     <= 1'b0;
                            r_cnt     <= '0;
                            rdata     <= '0;
                            busy      <= 1'b1;
                            cmd_valid <= 1'b1;
                            cmd_op    <= c_OP_START;
                            cmd_byte  <= '0;
                            r_state   <= S_START;
                        end
                    end
                    S_DONE: begin
                        r_rr    <= (r_gnt == c_GW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        if (r_outst && rsp_valid) begin
                            r_outst   <= 1'b0;
                            cmd_valid <= 1'b1;
                            if (w_is_wr && rsp_nack) begin
                                r_err    <= 1'b1;
                                cmd_op   <= c_OP_STOP;
                                cmd_byte <= '0;
                                r_state  <= S_STOP;
                            end else begin
                                case (r_state)
                                    S_START: begin
                                        cmd_op   <= c_OP_WRITE;
                                        cmd_byte <= {r_dev, 1'b0};
                                        r_state  <= S_DEVW;
                                    end
                                    S_DEVW: begin
                                        cmd_op   <= c_OP_WRITE;
                                        cmd_byte <= r_reg;
                                        r_state  <= S_REG;
                                    end
                                    S_REG: begin
                                        if (r_rw) begin
                                            cmd_op   <= c_OP_RSTART;
                                            cmd_byte <= '0;
                                            r_state  <= S_RSTART;
                                        end else begin
                                            cmd_op   <= c_OP_WRITE;
                                            cmd_byte <= r_wdata[7:0];
                                            r_cnt    <= '0;
                                            r_state  <= S_WDATA;
                                        end
                                    end
                                    S_WDATA: begin
                                        if (r_cnt == r_len) begin
                                            cmd_op   <= c_OP_STOP;
                                            cmd_byte <= '0;
                                            r_state  <= S_STOP;
                                        end else begin
                                            r_cnt    <= w_cnt_inc;
                                            cmd_op   <= c_OP_WRITE;
                                            cmd_byte <= w_wbyte;
                                        end
                                    end
                                    S_RSTART: begin
                                        cmd_op   <= c_OP_WRITE;
                                        cmd_byte <= {r_dev, 1'b1};
                                        r_state  <= S_DEVR;
                                    end
                                    S_DEVR: begin
                                        r_cnt    <= '0;
                                        cmd_op   <= (r_len == 2'd0) ? c_OP_RNACK : c_OP_RACK;
                                        cmd_byte <= '0;
                                        r_state  <= S_RDATA;
                                    end
                                    S_RDATA: begin
                                        rdata[{r_cnt, 3'b000} +: 8] <= rsp_byte;
                                        if (r_cnt == r_len) begin
                                            cmd_op   <= c_OP_STOP;
                                            r_state  <= S_STOP;
                                        end else begin
                                            r_cnt  <= w_cnt_inc;
                                            cmd_op <= (w_cnt_inc == r_len) ? c_OP_RNACK : c_OP_RACK;
                                        end
                                        cmd_byte <= '0;
                                    end
                                    S_STOP: begin
                                        cmd_valid       <= 1'b0;
                                        req_done[r_gnt] <= 1'b1;
                                        req_err         <= r_err;
                                        busy            <= 1'b0;
                                        r_state         <= S_DONE;
                                    end
                                    default: begin
                                        cmd_valid <= 1'b0;
                                        r_state   <= S_IDLE;
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_i2c_txn_scheduler
// Brief    : Random multi-client traffic against a command-list reference model,
//            plus directed arbitration, reset and (I2C_TIMEOUT_EN) timeout cases.
// Revision : 1.0
// =============================================================================
module tb_i2c_txn_scheduler;

    localparam int c_N = 4;
`ifdef I2C_TIMEOUT_EN
    localparam int c_TMO = 16;
`else
    localparam int c_TMO = 4096;
`endif
    localparam logic [2:0] c_OP_START  = 3'd0;
    localparam logic [2:0] c_OP_RSTART = 3'd1;
    localparam logic [2:0] c_OP_WRITE  = 3'd2;
    localparam logic [2:0] c_OP_RACK   = 3'd3;
    localparam logic [2:0] c_OP_RNACK  = 3'd4;
    localparam logic [2:0] c_OP_STOP   = 3'd5;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_N-1:0]    req_valid;
    logic [c_N-1:0]    req_rw;
    logic [7*c_N-1:0]  req_dev;
    logic [8*c_N-1:0]  req_reg;
    logic [2*c_N-1:0]  req_len;
    logic [32*c_N-1:0] req_wdata;
    logic [c_N-1:0]    req_done;
    logic              req_err;
    logic [31:0]       rdata;
    logic              busy;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [7:0]        cmd_byte;
    logic              rsp_valid;
    logic              rsp_nack;
    logic [7:0]        rsp_byte;
    logic              timeout;

    i2c_txn_scheduler #(.NUM_REQ(c_N), .TIMEOUT_CYC(c_TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg),
        .req_len(req_len), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .rdata(rdata), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_byte(cmd_byte),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_byte(rsp_byte),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Per-client transaction descriptions (what each client asked for).
    logic        cl_rw   [c_N];
    logic [6:0]  cl_dev  [c_N];
    logic [7:0]  cl_reg  [c_N];
    logic [1:0]  cl_len  [c_N];
    logic [31:0] cl_wd   [c_N];
    logic [7:0]  cl_rdb  [c_N][4];
    int          cl_nack [c_N];

    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    logic [31:0] exp_rd;
    bit          ab;
    int          wcount;
    int          g_ref;
    int          cur;
    int          rr;
    bit          stall;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Engine model: random accept latency, random response latency.
    int          eng_wr, eng_rd, eng_dly;
    bit          eng_pend;
    logic        eng_nack;
    logic [7:0]  eng_byte;
    initial begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_byte = '0;
        eng_pend = 1'b0; eng_wr = 0; eng_rd = 0; eng_dly = 0; eng_nack = 1'b0; eng_byte = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_byte = '0;
            if (rst) begin
                eng_pend  = 1'b0;
                cmd_ready = 1'b0;
            end else if (eng_pend) begin
                cmd_ready = 1'b0;
                if (eng_dly == 0) begin
                    rsp_valid = 1'b1; rsp_nack = eng_nack; rsp_byte = eng_byte; eng_pend = 1'b0;
                end else eng_dly--;
            end else begin
                cmd_ready = !stall && ($urandom_range(0, 3) != 0);
                if (cmd_valid && cmd_ready) begin
                    log_q.push_back({cmd_op, cmd_byte});
                    eng_nack = 1'b0; eng_byte = '0;
                    case (cmd_op)
                        c_OP_START: begin eng_wr = 0; eng_rd = 0; end
                        c_OP_WRITE: begin eng_nack = (eng_wr == cl_nack[cur]); eng_wr++; end
                        c_OP_RACK, c_OP_RNACK: begin
                            if (eng_rd < 4) eng_byte = cl_rdb[cur][eng_rd];
                            eng_rd++;
                        end
                        default: ;
                    endcase
                    eng_pend = 1'b1;
                    eng_dly  = $urandom_range(0, 3);
                end else if (!busy && $urandom_range(0, 7) == 0) begin
                    rsp_valid = 1'b1; rsp_nack = 1'b1; rsp_byte = 8'hFF;
                end
            end
        end
    end

    task automatic set_client(input int i, input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                              input logic [1:0] len, input logic [31:0] wd, input logic [31:0] rb,
                              input int nk);
        cl_rw[i] = rw; cl_dev[i] = dev; cl_reg[i] = rg; cl_len[i] = len; cl_wd[i] = wd;
        cl_nack[i] = nk;
        for (int k = 0; k < 4; k++) cl_rdb[i][k] = rb[8*k +: 8];
        req_rw[i] = rw;
        req_dev[7*i +: 7]    = dev;
        req_reg[8*i +: 8]    = rg;
        req_len[2*i +: 2]    = len;
        req_wdata[32*i +: 32] = wd;
        req_valid[i] = 1'b1;
    endtask

    task automatic rand_client(input int i);
        logic       rw;
        logic [1:0] len;
        int         nk;
        rw  = 1'($urandom_range(0, 1));
        len = 2'($urandom_range(0, 3));
        nk  = -1;
        if ($urandom_range(0, 3) == 0) nk = rw ? $urandom_range(0, 2) : $urandom_range(0, 2 + int'(len));
        set_client(i, rw, 7'($urandom), 8'($urandom), len, $urandom, $urandom, nk);
    endtask

    function automatic int predict();
        for (int i = 0; i < c_N; i++)
            if (req_valid[(rr + i) % c_N]) return (rr + i) % c_N;
        return -1;
    endfunction

    // Reference command list: commands up to and including a NACKed write, then STOP.
    task automatic exp_op(input logic [2:0] op, input logic [7:0] b);
        if (!ab) begin
            exp_q.push_back({op, b});
            if (op == c_OP_WRITE) begin
                if (wcount == cl_nack[g_ref]) ab = 1'b1;
                wcount++;
            end
        end
    endtask

    task automatic build_exp(input int g);
        exp_q = {}; ab = 1'b0; wcount = 0; g_ref = g;
        exp_op(c_OP_START, 8'h00);
        exp_op(c_OP_WRITE, {cl_dev[g], 1'b0});
        exp_op(c_OP_WRITE, cl_reg[g]);
        if (!cl_rw[g]) begin
            for (int k = 0; k <= int'(cl_len[g]); k++) exp_op(c_OP_WRITE, cl_wd[g][8*k +: 8]);
        end else begin
            exp_op(c_OP_RSTART, 8'h00);
            exp_op(c_OP_WRITE, {cl_dev[g], 1'b1});
            for (int k = 0; k < int'(cl_len[g]); k++) exp_op(c_OP_RACK, 8'h00);
            exp_op(c_OP_RNACK, 8'h00);
        end
        exp_q.push_back({c_OP_STOP, 8'h00});
        exp_rd = '0;
        if (cl_rw[g] && !ab)
            for (int k = 0; k <= int'(cl_len[g]); k++) exp_rd[8*k +: 8] = cl_rdb[g][k];
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " req_done"}, 32'(req_done), 0);
        chk({nm, " req_err"}, 32'(req_err), 0);
        chk({nm, " rdata"}, rdata, 0);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " cmd_valid"}, 32'(cmd_valid), 0);
        chk({nm, " cmd_op"}, 32'(cmd_op), 0);
        chk({nm, " cmd_byte"}, 32'(cmd_byte), 0);
        chk({nm, " timeout"}, 32'(timeout), 0);
    endtask

    task automatic run_one(input string nm);
        int g;
        bit seen;
        bit busy_ok;
        g = predict();
        if (g < 0) begin
            chk({nm, " has request"}, 0, 1);
            return;
        end
        cur = g;
        build_exp(g);
        log_q = {};
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = busy;
        end
        chk({nm, " busy rise"}, 32'(seen), 1);
        chk({nm, " rdata cleared"}, rdata, 0);
        if ($urandom_range(0, 4) == 0) req_valid[g] = 1'b0;
        seen = 1'b0; busy_ok = 1'b1;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (req_done != '0) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        chk({nm, " done seen"}, 32'(seen), 1);
        chk({nm, " busy held"}, 32'(busy_ok), 1);
        chk({nm, " grant"}, 32'(req_done), 32'(1) << g);
        chk({nm, " err"}, 32'(req_err), 32'(ab));
        chk({nm, " busy drop"}, 32'(busy), 0);
        chk({nm, " timeout"}, 32'(timeout), 0);
        chk({nm, " rdata"}, rdata, exp_rd);
        chk({nm, " ncmd"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
            chk($sformatf("%s op%0d", nm, k), 32'(log_q[k][10:8]), 32'(exp_q[k][10:8]));
            if (exp_q[k][10:8] == c_OP_WRITE)
                chk($sformatf("%s byte%0d", nm, k), 32'(log_q[k][7:0]), 32'(exp_q[k][7:0]));
        end
        req_valid[g] = 1'b0;
        rr = (g + 1) % c_N;
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(req_done), 0);
    endtask

    initial begin
        int g;
        bit seen;
        int cnt;
        rst = 1'b1; req_valid = '0; req_rw = '0; req_dev = '0; req_reg = '0; req_len = '0;
        req_wdata = '0; stall = 1'b0; cur = 0; rr = 0;
        for (int i = 0; i < c_N; i++) cl_nack[i] = -1;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b0;

        set_client(0, 1'b0, 7'h50, 8'h10, 2'd1, 32'h0000_BEEF, 32'h0, -1);
        set_client(1, 1'b1, 7'h50, 8'h20, 2'd2, 32'h0, 32'h0033_2211, -1);
        set_client(2, 1'b0, 7'h50, 8'h30, 2'd0, 32'h0000_005A, 32'h0, 0);
        rand_client(3);
        run_one("wr_example");
        run_one("rd_example");
        chk("rd_example value", rdata, 32'h0033_2211);
        run_one("nack_dev");
        run_one("client3");

        rand_client(2);
        run_one("rr_to_3");
        rand_client(2);
        rand_client(3);
        run_one("rr_grant3");
        run_one("rr_grant2");

        repeat (40) begin
            for (int i = 0; i < c_N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_client(i);
            if (req_valid == '0) rand_client($urandom_range(0, c_N - 1));
            run_one("rnd");
        end

        req_valid = '0;
        set_client(1, 1'b1, 7'h3C, 8'h44, 2'd3, 32'h0, 32'hDDCC_BBAA, -1);
        g = predict();
        cur = g;
        log_q = {};
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = (log_q.size() >= 7);
        end
        chk("midrd reached", 32'(seen), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outs("midrd");
        @(negedge clk);
        chk("midrd no done", 32'(req_done), 0);
        rst = 1'b0;
        req_valid = '0;
        rr = 0;
        set_client(2, 1'b0, 7'h11, 8'h22, 2'd2, 32'h0077_6655, 32'h0, -1);
        run_one("post_rst");

`ifdef I2C_TIMEOUT_EN
        stall = 1'b1;
        set_client(0, 1'b0, 7'h50, 8'h10, 2'd0, 32'h0000_0011, 32'h0, -1);
        g = predict();
        cur = g;
        log_q = {};
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = busy;
        end
        chk("tmo busy", 32'(seen), 1);
        seen = 1'b0; cnt = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            cnt++;
            seen = timeout;
        end
        chk("tmo seen", 32'(seen), 1);
        chk("tmo cycles", 32'(cnt), 32'(c_TMO));
        chk("tmo done", 32'(req_done), 32'(1) << g);
        chk("tmo err", 32'(req_err), 1);
        chk("tmo no cmds", 32'(log_q.size()), 0);
        stall = 1'b0;
        req_valid[g] = 1'b0;
        rr = (g + 1) % c_N;
        @(negedge clk);
        chk("tmo pulse", 32'(timeout), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
